// File: rtl/pipe_cla_adder.sv
`default_nettype none
// ============================================================================
// Module      : pipe_cla_adder
// Description : Pipelined, parametrised carry-lookahead adder. The WIDTH-bit
//               add is split into WIDTH/GROUP lookahead groups, one group per
//               pipeline stage, with the group carry registered between
//               stages. Valid/ready handshake on both sides, one beat/cycle.
// Parameters  : WIDTH - operand/sum width (multiple of GROUP)
//               GROUP - bits per lookahead group (1..8)
// Ports       : clk, rst             - clock, synchronous active-high reset
//               in_valid/in_ready    - operand beat handshake
//               a, b, cin            - operands and carry in
//               out_valid/out_ready  - result beat handshake
//               s, cout              - registered sum and carry out
//               ovf                  - signed overflow (PIPE_CLA_OVF_EN only)
// Options     : define PIPE_CLA_OVF_EN to add the registered ovf output
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_cla_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef PIPE_CLA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int c_NSTG = WIDTH / GROUP;
  // Operand registers are only needed between stages; keep at least one
  // entry so the array stays legal when the whole add fits in one stage.
  localparam int c_NOPS = (c_NSTG > 1) ? c_NSTG - 1 : 1;

  generate
    if ((GROUP < 1) || (GROUP > 8) || ((WIDTH % GROUP) != 0)) begin : g_bad_param
      $error("pipe_cla_adder: GROUP must be 1..8 and divide WIDTH");
    end
  endgenerate

  // Full lookahead: every carry c[i+1] is a flat OR of g[j]&p[j+1..i] terms
  // plus ci&p[0..i]; no carry is derived from another carry of the group.
  function automatic logic [GROUP:0] cla_carries(
    input logic [GROUP-1:0] p,
    input logic [GROUP-1:0] g,
    input logic             ci
  );
    logic [GROUP:0] c;
    logic           term;
    c    = '0;
    term = 1'b0;
    c[0] = ci;
    for (int i = 0; i < GROUP; i++) begin
      term = ci;
      for (int j = 0; j <= i; j++) term = term & p[j];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

  // Stage registers
  logic [c_NSTG-1:0] r_vld;
  logic [c_NSTG-1:0] r_cy;
  logic [WIDTH-1:0]  r_sum [c_NSTG];
  // Unprocessed operand bits, shifted down so the next group sits at bit 0
  logic [WIDTH-1:0]  r_a   [c_NOPS];
  logic [WIDTH-1:0]  r_b   [c_NOPS];

  // Next-state values per stage
  logic [WIDTH-1:0]  w_sum_nxt [c_NSTG];
  logic [c_NSTG-1:0] w_cy_nxt;
  logic [WIDTH-1:0]  w_a_nxt   [c_NOPS];
  logic [WIDTH-1:0]  w_b_nxt   [c_NOPS];
  logic              w_adv;
`ifdef PIPE_CLA_OVF_EN
  logic              w_cmsb;
  logic              r_ovf;
`endif

  assign w_adv     = !r_vld[c_NSTG-1] || out_ready;
  assign in_ready  = w_adv || rst;
  assign out_valid = r_vld[c_NSTG-1];
  assign s         = r_sum[c_NSTG-1];
  assign cout      = r_cy[c_NSTG-1];
`ifdef PIPE_CLA_OVF_EN
  assign ovf       = r_ovf;
`endif

  always_comb begin
    logic [WIDTH-1:0] w_ai;
    logic [WIDTH-1:0] w_bi;
    logic [WIDTH-1:0] w_si;
    logic             w_ci;
    logic [GROUP-1:0] w_p;
    logic [GROUP-1:0] w_g;
    logic [GROUP:0]   w_c;
    w_ai     = '0;
    w_bi     = '0;
    w_si     = '0;
    w_ci     = 1'b0;
    w_p      = '0;
    w_g      = '0;
    w_c      = '0;
    w_cy_nxt = '0;
`ifdef PIPE_CLA_OVF_EN
    w_cmsb   = 1'b0;
`endif
    for (int k = 0; k < c_NSTG; k++) w_sum_nxt[k] = '0;
    for (int k = 0; k < c_NOPS; k++) begin
      w_a_nxt[k] = '0;
      w_b_nxt[k] = '0;
    end
    for (int k = 0; k < c_NSTG; k++) begin
      if (k == 0) begin
        w_ai = a;
        w_bi = b;
        w_si = '0;
        w_ci = cin;
      end else begin
        w_ai = r_a[(k == 0) ? 0 : k - 1];
        w_bi = r_b[(k == 0) ? 0 : k - 1];
        w_si = r_sum[(k == 0) ? 0 : k - 1];
        w_ci = r_cy[(k == 0) ? 0 : k - 1];
      end
      w_p = w_ai[GROUP-1:0] ^ w_bi[GROUP-1:0];
      w_g = w_ai[GROUP-1:0] & w_bi[GROUP-1:0];
      w_c = cla_carries(w_p, w_g, w_ci);
      w_sum_nxt[k] = w_si;
      w_sum_nxt[k][k*GROUP +: GROUP] = w_p ^ w_c[GROUP-1:0];
      w_cy_nxt[k] = w_c[GROUP];
      if (k < c_NSTG - 1) begin
        w_a_nxt[k % c_NOPS] = w_ai >> GROUP;
        w_b_nxt[k % c_NOPS] = w_bi >> GROUP;
      end
`ifdef PIPE_CLA_OVF_EN
      // Carry into the MSB is the last internal carry of the final group
      if (k == c_NSTG - 1) w_cmsb = w_c[GROUP-1];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      r_cy  <= '0;
      for (int k = 0; k < c_NSTG; k++) r_sum[k] <= '0;
      for (int k = 0; k < c_NOPS; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
      end
`ifdef PIPE_CLA_OVF_EN
      r_ovf <= 1'b0;
`endif
    end else if (w_adv) begin
      // All stages move together; bubbles travel through unchanged
      r_vld[0] <= in_valid;
      for (int k = 1; k < c_NSTG; k++) r_vld[k] <= r_vld[k-1];
      r_cy <= w_cy_nxt;
      for (int k = 0; k < c_NSTG; k++) r_sum[k] <= w_sum_nxt[k];
      for (int k = 0; k < c_NOPS; k++) begin
        r_a[k] <= w_a_nxt[k];
        r_b[k] <= w_b_nxt[k];
      end
`ifdef PIPE_CLA_OVF_EN
      r_ovf <= w_cmsb ^ w_cy_nxt[c_NSTG-1];
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_cla_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_cla_adder
// Description : Directed self-checking bench for pipe_cla_adder. Instances:
//               16-bit/GROUP 4 (main) and 8-bit/GROUP 1 (deep pipeline).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_cla_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, cin, cout;
  logic [15:0] a, b, s;
  logic        in_valid8, in_ready8, out_valid8, out_ready8, cin8, cout8;
  logic [7:0]  a8, b8, s8;
`ifdef PIPE_CLA_OVF_EN
  logic        ovf, ovf8;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_cla_adder #(.WIDTH(16), .GROUP(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout)
`ifdef PIPE_CLA_OVF_EN
    , .ovf(ovf)
`endif
  );

  pipe_cla_adder #(.WIDTH(8), .GROUP(1)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .s(s8), .cout(cout8)
`ifdef PIPE_CLA_OVF_EN
    , .ovf(ovf8)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; a = 16'h0005; b = 16'h0003; cin = 1'b0;
    out_ready = 1'b1;
    tick; tick;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (s !== 16'h0000) begin failures++; $display("FAIL rst_s got=%h exp=0000", s); end
    checks++; if (cout !== 1'b0) begin failures++; $display("FAIL rst_cout got=%b exp=0", cout); end
    checks++; if (out_valid8 !== 1'b0) begin failures++; $display("FAIL rst_out_valid8 got=%b exp=0", out_valid8); end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_rst_in_ready got=%b exp=1", in_ready); end
    // The beat shown during reset must never come out
    for (int k = 0; k < 6; k++) begin
      tick;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_no_accept cyc=%0d got=%b exp=0", k, out_valid); end
    end
  endtask

  task automatic test_carry_chain;
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) tick;
      if (k == 4) begin
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL chain_valid got=%b exp=1", out_valid); end
        checks++; if ({cout, s} !== 17'h10000) begin failures++; $display("FAIL chain_sum got=%b_%h exp=1_0000", cout, s); end
      end else begin
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL chain_latency k=%0d got=%b exp=0", k, out_valid); end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [16:0] exp_q [8];
    out_ready = 1'b1;
    for (int t = 0; t < 13; t++) begin
      if (t < 8) begin
        a = 16'(t * 16'h1111); b = 16'h0F0F; cin = 1'(t & 1); in_valid = 1'b1;
        exp_q[t] = {1'b0, a} + {1'b0, b} + {16'h0, cin};
      end else begin
        in_valid = 1'b0;
      end
      tick;
      if (t >= 3 && t <= 10) begin
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid t=%0d got=%b exp=1", t, out_valid); end
        checks++; if ({cout, s} !== exp_q[t-3]) begin failures++; $display("FAIL b2b_sum beat=%0d got=%h exp=%h", t - 3, {cout, s}, exp_q[t-3]); end
      end else begin
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle t=%0d got=%b exp=0", t, out_valid); end
      end
    end
  endtask

  task automatic test_backpressure;
    logic [16:0] q [$];
    logic [16:0] held;
    logic        stall, acc, pop;
    int          sent, recv;
    sent = 0; recv = 0;
    for (int t = 0; t < 40 && recv < 8; t++) begin
      out_ready = !(t >= 6 && t < 9);
      if (sent < 8) begin
        a = 16'(16'h0101 * (sent + 1)); b = 16'hF00F; cin = 1'(sent & 1); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      stall = out_valid && !out_ready;
      if (stall) begin
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready t=%0d got=%b exp=0", t, in_ready); end
      end
      acc  = in_valid && in_ready;
      pop  = out_valid && out_ready;
      held = {cout, s};
      if (pop) begin
        checks++;
        if (q.size() == 0) begin failures++; $display("FAIL bp_extra_beat got=%h exp=none", {cout, s}); end
        else begin
          if ({cout, s} !== q[0]) begin failures++; $display("FAIL bp_sum beat=%0d got=%h exp=%h", recv, {cout, s}, q[0]); end
          void'(q.pop_front());
        end
        recv++;
      end
      if (acc) begin
        q.push_back({1'b0, a} + {1'b0, b} + {16'h0, cin});
        sent++;
      end
      @(posedge clk); #1;
      if (stall) begin
        checks++; if (out_valid !== 1'b1 || {cout, s} !== held) begin failures++; $display("FAIL bp_hold t=%0d got=%b/%h exp=1/%h", t, out_valid, {cout, s}, held); end
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (recv != 8 || sent != 8) begin failures++; $display("FAIL bp_count got=%0d/%0d exp=8/8", sent, recv); end
  endtask

  task automatic test_reset_midflight;
    out_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      a = 16'(16'h0111 * (t + 1)); b = 16'h0222; cin = 1'b1; in_valid = 1'b1;
      tick;
    end
    in_valid = 1'b0; rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || s !== 16'h0 || cout !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL midrst_state got=v%b s%h c%b r%b exp=v0 s0000 c0 r1", out_valid, s, cout, in_ready);
    end
    a = 16'h1234; b = 16'h4321; cin = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) tick;
      if (k == 4) begin
        checks++; if (out_valid !== 1'b1 || {cout, s} !== 17'h05555) begin failures++; $display("FAIL midrst_new got=v%b %h exp=v1 05555", out_valid, {cout, s}); end
      end else begin
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_stale k=%0d got=%b exp=0", k, out_valid); end
      end
    end
  endtask

`ifdef PIPE_CLA_OVF_EN
  task automatic test_ovf;
    logic [15:0] va [3];
    logic [15:0] vb [3];
    logic        vc [3];
    logic [17:0] ve [3];   // {ovf, cout, s}
    va[0] = 16'h7FFF; vb[0] = 16'h0000; vc[0] = 1'b1; ve[0] = 18'h28000;
    va[1] = 16'h8000; vb[1] = 16'h8000; vc[1] = 1'b0; ve[1] = 18'h30000;
    va[2] = 16'h0001; vb[2] = 16'h0001; vc[2] = 1'b0; ve[2] = 18'h00002;
    out_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      if (t < 3) begin a = va[t]; b = vb[t]; cin = vc[t]; in_valid = 1'b1; end
      else in_valid = 1'b0;
      tick;
      if (t >= 3) begin
        checks++; if (out_valid !== 1'b1 || {ovf, cout, s} !== ve[t-3]) begin failures++; $display("FAIL ovf beat=%0d got=v%b %h exp=v1 %h", t - 3, out_valid, {ovf, cout, s}, ve[t-3]); end
      end
    end
  endtask
`endif

  task automatic test_group1;
    out_ready8 = 1'b1;
    a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1; in_valid8 = 1'b1;
    tick;
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
    tick;
    in_valid8 = 1'b0;
    for (int k = 2; k <= 10; k++) begin
      if (k > 2) tick;
      if (k == 8) begin
        checks++; if (out_valid8 !== 1'b1 || {cout8, s8} !== 9'h100) begin failures++; $display("FAIL g1_beat0 got=v%b %h exp=v1 100", out_valid8, {cout8, s8}); end
      end else if (k == 9) begin
        checks++; if (out_valid8 !== 1'b1 || {cout8, s8} !== 9'h046) begin failures++; $display("FAIL g1_beat1 got=v%b %h exp=v1 046", out_valid8, {cout8, s8}); end
      end else begin
        checks++; if (out_valid8 !== 1'b0) begin failures++; $display("FAIL g1_latency k=%0d got=%b exp=0", k, out_valid8); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0;
    test_reset;
    test_carry_chain;
    test_back_to_back;
    test_backpressure;
    test_reset_midflight;
`ifdef PIPE_CLA_OVF_EN
    test_ovf;
`endif
    test_group1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
